// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier over an 8-bit ripple-carry adder.
// Optional feature macro: MUL_ZERO_BYPASS_EN (zero operand finishes in one cycle).

// Plain ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module shift_add_ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    // Full-adder chain; the critical path is the full WIDTH-stage ripple.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
        cout = c[WIDTH];
    end

endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ZERO = 2'd3;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   mq;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] shifted;
    logic               take;
    logic               zero_op;
    logic               last;

    // Multiplier bit selects whether the multiplicand joins this pass.
    always_comb begin
        addend  = mq[0] ? mcand : '0;
        shifted = {cout, sum, mq[WIDTH-1:1]};
        last    = (cnt == CW'(1));
    end

    shift_add_ripple_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x    (acc_hi),
        .y    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Start is honoured only when no iteration is in flight.
    always_comb begin
        take = start && ((state == IDLE) || (state == DONE));
`ifdef MUL_ZERO_BYPASS_EN
        zero_op = (a == '0) || (b == '0);
`else
        zero_op = 1'b0;
`endif
    end

    // Control FSM and shift-add datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            mq     <= '0;
            cnt    <= '0;
            prod_q <= '0;
        end else begin
            unique case (1'b1)
                (state == RUN): begin
                    {acc_hi, mq} <= shifted;
                    cnt          <= cnt - CW'(1);
                    if (last) begin
                        prod_q <= shifted;
                        state  <= DONE;
                    end
                end
                (state == ZERO): begin
                    prod_q <= '0;
                    state  <= DONE;
                end
                (take && zero_op): begin
                    state <= ZERO;
                end
                (take && !zero_op): begin
                    mcand  <= a;
                    mq     <= b;
                    acc_hi <= '0;
                    cnt    <= CW'(WIDTH);
                    state  <= RUN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags decode straight from the state register.
    always_comb begin
        busy    = (state == RUN);
        done    = (state == DONE);
        product = prod_q;
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

- Sequential unsigned WIDTH×WIDTH multiplier using the 8-bit ripple-carry adder as its datapath.
- Each cycle it presents the partial-product high half and the multiplicand to the adder, then consumes the sum and carry-out.
- Produces a 2×WIDTH product with a start/done handshake.
- Sits between operand sources (register file / testbench stimulus) and the adder stage; it is the adder's only driver in the arithmetic unit.

## Interface

Parameters:
- WIDTH, 8, operand width. Equals the adder width; only 8 is supported with the ripple adder instance.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled on clk rise when state is not RUN.
- a  input  WIDTH  multiplicand; latched on accepted start.
- b  input  WIDTH  multiplier; latched on accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse: product is valid.
- product  output  2*WIDTH  registered result; holds until the next completion.

Reset:
- One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation

Internal registers:
- mcand[WIDTH], acc_hi[WIDTH], mq[WIDTH], cnt[$clog2(WIDTH+1)].

States:
- IDLE: busy=0, done=0. start=1 → load mcand=a, mq=b, acc_hi=0, cnt=WIDTH; go to RUN.
- RUN: one iteration per cycle.
  - Adder inputs: A=acc_hi, B = mq[0] ? mcand : 0, carry=0.
  - Update: {acc_hi, mq} ← {cout, sum, mq[WIDTH-1:1]}, i.e. a WIDTH+1-bit sum shifted right by one.
  - cnt decrements by 1.
  - When cnt==1, the iteration also writes product ← final {acc_hi, mq} and moves to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 → load operands and go to RUN (back-to-back).
  - Otherwise go to IDLE.

Rules:
- start while in RUN is ignored; there is no queueing.
- a and b may change freely after the accepted start edge.
- Arithmetic: unsigned only. The product never overflows 2*WIDTH bits; cout of every add is retained as the new acc_hi MSB.
- product updates only on the completion edge and never shows partial values.

## Timing

- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- Reset mid-RUN aborts the operation: no done, product=0.
- Start accepted at edge E0. busy=1 after E0 through edge E_WIDTH.
- product is written and done rises at edge E_WIDTH; done falls at E_WIDTH+1.
- Latency is WIDTH cycles from start edge to done; throughput is one result per WIDTH+1 cycles.
- With start held high through DONE, throughput is one result per WIDTH cycles plus the DONE cycle reused as the next load.
- Iteration is combinational through one adder pass per cycle; the clock period must cover the full 8-stage ripple.

## Configuration

- MUL_ZERO_BYPASS_EN defined:
  - On an accepted start with a==0 or b==0, go directly to DONE.
  - product ← 0 at the next edge; done pulses one cycle after start (latency 1). busy stays 0.
- MUL_ZERO_BYPASS_EN undefined:
  - Zero operands take the normal WIDTH-cycle path.
  - Result is still 0, with done at E_WIDTH.

## Test plan

- a=0x0D, b=0x0B, start 1 cycle → busy 8 cycles, done pulse, product=0x008F; product holds 0x008F afterward.
- a=0xFF, b=0xFF → product=0xFE01 (exercises cout on every add); then a=0x80, b=0x02 → 0x0100.
- start re-pulsed with a=0x03, b=0x03 at cycle 3 of a running 0x0D×0x0B → ignored; product=0x008F, exactly one done.
- rst_n low at RUN cycle 4 → busy, done and product go 0 immediately; after release, 0x12×0x34 yields 0x03A8.
- start held high with 0x02×0x03, then 0x04×0x05 applied in the DONE cycle → done twice, products 0x0006 then 0x0014, with no IDLE cycle between.
- a=0x00, b=0x5A → product=0x0000. With MUL_ZERO_BYPASS_EN: done 1 cycle after start, busy never high. Without it: done after 8 cycles.
